// File: rtl/apb_wr_req_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package : apb_ic_pkg
// Brief   : Shared APB interconnect widths and write-request record type.
// Rev     : 1.0  initial release
// ============================================================================
package apb_ic_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } wr_req_t;

endpackage : apb_ic_pkg
`default_nettype wire

// File: rtl/apb_wr_req_fifo_if.sv
`default_nettype none
// ============================================================================
// Interface : apb_wr_req_fifo_if
// Brief     : Push side (slave stage) and pop side (arbiter) of the write FIFO.
// Rev       : 1.0  initial release
// ============================================================================
interface apb_wr_req_fifo_if #(
  parameter int CNT_W = 4
);
  import apb_ic_pkg::*;

  logic              push_in;
  logic              fifo_write;
  logic [ADDR_W-1:0] push_addr_in;
  logic [DATA_W-1:0] push_wdata_in;
  logic              fifo_data_in_ack;
  logic              full_o;
  logic              empty_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic              pop_valid_o;
  logic              pop_ready_i;
  logic [ADDR_W-1:0] pop_addr_o;
  logic [DATA_W-1:0] pop_wdata_o;

  // FIFO side of the link
  modport slave (
    input  push_in, fifo_write, push_addr_in, push_wdata_in, pop_ready_i,
    output fifo_data_in_ack, full_o, empty_o, count_o, overflow_o,
           pop_valid_o, pop_addr_o, pop_wdata_o
  );

  // Producer/consumer side of the link
  modport master (
    output push_in, fifo_write, push_addr_in, push_wdata_in, pop_ready_i,
    input  fifo_data_in_ack, full_o, empty_o, count_o, overflow_o,
           pop_valid_o, pop_addr_o, pop_wdata_o
  );

endinterface : apb_wr_req_fifo_if
`default_nettype wire

// File: rtl/apb_wr_req_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module : apb_wr_req_fifo_mem
// Brief  : DEPTH x wr_req_t storage, one synchronous write, one async read.
// Rev    : 1.0  initial release
// ============================================================================
module apb_wr_req_fifo_mem
  import apb_ic_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  wr_req_t          wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output wr_req_t          rdata_o
);

  // Storage is intentionally not reset; occupancy tracking lives in the top.
  wr_req_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : apb_wr_req_fifo_mem
`default_nettype wire

// File: rtl/apb_wr_req_fifo.sv
`default_nettype none
// ============================================================================
// Module : apb_wr_req_fifo
// Brief  : First-word fall-through write-request FIFO between APB slave stage
//          and round-robin arbiter, with registered push ack and sticky overflow.
// Rev    : 1.0  initial release
// ============================================================================
module apb_wr_req_fifo
  import apb_ic_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_wr_req_fifo_if.slave  bus_if
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ack_q,    ack_d;
  logic             overflow_q, overflow_d;

  logic    full_w;
  logic    empty_w;
  logic    push_req_w;
  logic    push_acc_w;
  logic    pop_acc_w;
  wr_req_t push_data_w;
  wr_req_t head_w;

  // Flags depend only on registered occupancy, never on this cycle's strobes.
  assign full_w     = (count_q == CNT_FULL);
  assign empty_w    = (count_q == '0);
  assign push_req_w = bus_if.push_in & bus_if.fifo_write;
  assign push_acc_w = push_req_w & ~full_w;
  assign pop_acc_w  = ~empty_w & bus_if.pop_ready_i;

  assign push_data_w.addr  = bus_if.push_addr_in;
  assign push_data_w.wdata = bus_if.push_wdata_in;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ack_d      = push_acc_w;
    overflow_d = overflow_q | (push_req_w & full_w);

    if (push_acc_w) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_acc_w) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push_acc_w, pop_acc_w})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_q      <= ack_d;
      overflow_q <= overflow_d;
    end
  end

  apb_wr_req_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (PCLK),
    .we_i    (push_acc_w),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_data_w),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_w)
  );

  assign bus_if.fifo_data_in_ack = ack_q;
  assign bus_if.full_o           = full_w;
  assign bus_if.empty_o          = empty_w;
  assign bus_if.count_o          = count_q;
  assign bus_if.overflow_o       = overflow_q;
  assign bus_if.pop_valid_o      = ~empty_w;
  assign bus_if.pop_addr_o       = head_w.addr;
  assign bus_if.pop_wdata_o      = head_w.wdata;

endmodule : apb_wr_req_fifo
`default_nettype wire
